// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared memory-port widths and mem_master state encodings
package mem_master_pkg;
  localparam int ADD_BUS_WIDTH = 32;
  localparam int DATA_WIDTH = 16;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR0 = 3'd1;
  localparam logic [2:0] WR1 = 3'd2;
  localparam logic [2:0] RD0 = 3'd3;
  localparam logic [2:0] RD0W = 3'd4;
  localparam logic [2:0] RD1 = 3'd5;
  localparam logic [2:0] RD1W = 3'd6;
endpackage

// File: rtl/mem_master.sv
// mem_master: sequences single/double-word load/store requests into single-word memory transactions
module mem_master
  import mem_master_pkg::*;
#(
  parameter int addBusWidth = ADD_BUS_WIDTH,
  parameter int width = DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic                   dbl,
  input  logic [addBusWidth-1:0] addr,
  input  logic [2*width-1:0]     wdata,
  output logic                   busy,
  output logic                   done,
  output logic [2*width-1:0]     rdata,
  output logic                   memR,
  output logic                   memWR,
  output logic [addBusWidth-1:0] addR,
  output logic [addBusWidth-1:0] addWR,
  output logic [width-1:0]       dataWR,
  input  logic [width-1:0]       dataR
);
  logic [2:0] state, nxt;
  logic [addBusWidth-1:0] a, a1, ma;
  logic [2*width-1:0] wd;
  logic d, wr_st, rd_st;
  always_comb begin
    nxt = state == IDLE ? (req ? (we ? WR0 : RD0) : IDLE) :
          state == WR0  ? (d ? WR1 : IDLE) :
          state == RD0  ? RD0W :
          state == RD0W ? (d ? RD1 : IDLE) :
          state == RD1  ? RD1W : IDLE;
    wr_st = state == WR0 || state == WR1;
    rd_st = state == RD0 || state == RD0W || state == RD1 || state == RD1W;
    a1 = a + {{(addBusWidth-1){1'b0}}, 1'b1};
    ma = (state == WR1 || state == RD1 || state == RD1W) ? a1 : a;
    busy = state != IDLE;
    memWR = wr_st;
    memR = rd_st;
    addR = (wr_st || rd_st) ? ma : '0;
    addWR = (wr_st || rd_st) ? ma : '0;
    dataWR = state == WR0 ? (d ? wd[2*width-1:width] : wd[width-1:0]) :
             state == WR1 ? wd[width-1:0] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      rdata <= '0;
      a <= '0;
      wd <= '0;
      d <= 1'b0;
    end else begin
      state <= nxt;
      done <= busy && nxt == IDLE;
      if (state == IDLE && req) begin
        a <= addr;
        wd <= wdata;
        d <= dbl;
      end
      if (state == RD0W) rdata <= d ? {dataR, rdata[width-1:0]} : {{width{1'b0}}, dataR};
      if (state == RD1W) rdata[width-1:0] <= dataR;
    end
  end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: scoreboard bench for mem_master with a behavioural word memory
module tb_mem_master;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, dbl = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic busy, done, memR, memWR;
  logic [31:0] rdata, addR, addWR;
  logic [15:0] dataWR;
  logic [15:0] dataR = '0;
  int tests = 0, fails = 0;
  logic [15:0] mem[logic [31:0]];
  logic [15:0] model[logic [31:0]];
  logic [47:0] exp_wr[$];
  logic [32:0] exp_done[$];
  logic prev_done = 1'b0;
  always #5 clk = ~clk;
  mem_master dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .dbl(dbl), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .memR(memR), .memWR(memWR),
    .addR(addR), .addWR(addWR), .dataWR(dataWR), .dataR(dataR)
  );
  always @(posedge clk) begin
    if (memWR) mem[addWR] = dataWR;
    if (memR) dataR <= mem.exists(addR) ? mem[addR] : 16'h0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (memR && memWR) begin
        fails++;
        $display("FAIL mutex: memR=%b memWR=%b, required not both high", memR, memWR);
      end
      tests++;
      if (done && prev_done) begin
        fails++;
        $display("FAIL done_pulse: done high two cycles in a row, required single-cycle pulse");
      end
      if (memWR) begin
        tests++;
        if (exp_wr.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: addWR=%h dataWR=%h, required no write", addWR, dataWR);
        end else begin
          logic [47:0] e;
          e = exp_wr.pop_front();
          if ({addWR, dataWR} !== e || addR !== addWR) begin
            fails++;
            $display("FAIL write: addWR=%h addR=%h dataWR=%h, required addr=%h data=%h", addWR, addR, dataWR, e[47:16], e[15:0]);
          end
        end
      end
      if (done) begin
        tests++;
        if (exp_done.size() == 0) begin
          fails++;
          $display("FAIL spurious_done: done=1, required no completion");
        end else begin
          logic [32:0] e;
          e = exp_done.pop_front();
          if (e[32] && rdata !== e[31:0]) begin
            fails++;
            $display("FAIL load_data: rdata=%h, required %h", rdata, e[31:0]);
          end
        end
      end
    end
    prev_done = done;
  end
  function automatic logic [15:0] rd_model(input logic [31:0] a);
    return model.exists(a) ? model[a] : 16'h0;
  endfunction
  task automatic do_op(input logic w, input logic d, input logic [31:0] a, input logic [31:0] wd, input int exp_lat, input int pulse_at, input string name);
    logic [31:0] a1;
    int lat;
    a1 = a + 32'd1;
    req = 1'b1; we = w; dbl = d; addr = a; wdata = wd;
    if (w) begin
      if (d) begin
        exp_wr.push_back({a, wd[31:16]});
        exp_wr.push_back({a1, wd[15:0]});
        model[a] = wd[31:16];
        model[a1] = wd[15:0];
      end else begin
        exp_wr.push_back({a, wd[15:0]});
        model[a] = wd[15:0];
      end
      exp_done.push_back({1'b0, 32'h0});
    end else begin
      exp_done.push_back({1'b1, d ? {rd_model(a), rd_model(a1)} : {16'h0, rd_model(a)}});
    end
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    lat = 1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_after_accept: busy=%b, required 1", name, busy);
    end
    while (!done && lat < 12) begin
      if (lat == pulse_at) begin
        req = 1'b1; we = 1'b1; dbl = 1'b0; addr = 32'h99; wdata = 32'h5555;
      end else req = 1'b0;
      @(negedge clk);
      lat++;
    end
    req = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required done at %0d", name, done, lat, exp_lat);
    end else if (lat != exp_lat) begin
      fails++;
      $display("FAIL %s latency: done at T+%0d, required T+%0d", name, lat, exp_lat);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_in_done: busy=%b, required 0", name, busy);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, memR, memWR, rdata, addR, addWR, dataWR} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b memR=%b memWR=%b rdata=%h addR=%h addWR=%h dataWR=%h, required all 0",
               busy, done, memR, memWR, rdata, addR, addWR, dataWR);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_single;
    do_op(1'b1, 1'b0, 32'h5, 32'h0000_BEEF, 2, 0, "single_store");
    do_op(1'b0, 1'b0, 32'h5, 32'h0, 3, 0, "single_load");
    tests++;
    if (rdata !== 32'h0000_BEEF) begin
      fails++;
      $display("FAIL single_load_const: rdata=%h, required 0000beef", rdata);
    end
  endtask
  task automatic test_double;
    do_op(1'b1, 1'b1, 32'h10, 32'h1234_ABCD, 3, 0, "double_store");
    tests++;
    if (mem[32'h10] !== 16'h1234 || mem[32'h11] !== 16'hABCD) begin
      fails++;
      $display("FAIL double_store_mem: [10]=%h [11]=%h, required 1234 abcd", mem[32'h10], mem[32'h11]);
    end
    do_op(1'b0, 1'b1, 32'h10, 32'h0, 5, 0, "double_load");
    tests++;
    if (rdata !== 32'h1234_ABCD) begin
      fails++;
      $display("FAIL double_load_const: rdata=%h, required 1234abcd", rdata);
    end
  endtask
  task automatic test_wrap;
    do_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D, 3, 0, "wrap_store");
    do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 5, 0, "wrap_load");
  endtask
  task automatic test_back_to_back;
    do_op(1'b0, 1'b0, 32'h10, 32'h0, 3, 0, "b2b_load");
    do_op(1'b1, 1'b0, 32'h20, 32'h0000_7777, 2, 0, "b2b_store");
    do_op(1'b0, 1'b1, 32'h10, 32'h0, 5, 2, "ignored_req_load");
    do_op(1'b1, 1'b1, 32'h30, 32'h0102_0304, 3, 1, "ignored_req_store");
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset_mid;
    req = 1'b1; we = 1'b0; dbl = 1'b1; addr = 32'h10;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (memR !== 1'b1 || addR !== 32'h11) begin
      fails++;
      $display("FAIL mid_rd1: memR=%b addR=%h, required 1 00000011", memR, addR);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || memR !== 1'b0 || rdata !== 32'h0 || done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b memR=%b rdata=%h done=%b, required 0 0 0 0", busy, memR, rdata, done);
    end
    repeat (6) @(negedge clk);
  endtask
  task automatic test_reset_priority;
    rst = 1'b1; req = 1'b1; we = 1'b1; dbl = 1'b0; addr = 32'h40; wdata = 32'h1111;
    @(posedge clk);
    #1 rst = 1'b0; req = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_priority: busy=%b, required 0", busy);
    end
    repeat (4) @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_single;
    test_double;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    test_reset_priority;
    tests++;
    if (exp_wr.size() != 0 || exp_done.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d writes %0d completions pending, required 0 0", exp_wr.size(), exp_done.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_master.md
# mem_master

Initiator for the data memory's two-port interface: it accepts one-word or double-word load/store requests from the pipeline's memory stage and sequences them into single-word transactions on the memory port. Double-word accesses carry 32-bit values (PC save/restore on CALL/RET/INT, PUSH/POP of PC) over the 16-bit memory. While `busy` is high the hazard unit stalls the pipeline; completion is signalled with a one-cycle `done` pulse.

## Interface
- `addBusWidth`, 32, memory address width.
- `width`, 16, memory word width; request data is `2*width`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req`  in  1  request strobe, sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `dbl`  in  1  1 = double-word access, 0 = single word.
- `addr`  in  addBusWidth  base word address.
- `wdata`  in  2*width  store data; single stores use `[width-1:0]`.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  2*width  load result; holds until the next load captures.
- `memR`  out  1  memory read enable.
- `memWR`  out  1  memory write enable.
- `addR`  out  addBusWidth  memory read address.
- `addWR`  out  addBusWidth  memory write address.
- `dataWR`  out  width  memory write data.
- `dataR`  in  width  memory read data.

## Operation
- **States:** IDLE, WR0, WR1, RD0, RD0W, RD1, RD1W.
- **Acceptance:** in IDLE with `req=1`, latch `addr`, `wdata`, `we` and `dbl`.
  - Store: go to WR0. Load: go to RD0.
  - A `req` seen outside IDLE is ignored, not queued.
- **Word order (big-endian):**
  - `addr` holds bits `[2*width-1:width]`; `addr+1` holds bits `[width-1:0]`.
  - `addr+1` wraps modulo 2^addBusWidth.
  - A single-word access uses `addr` only and the low half of `wdata`/`rdata`.
- **Stores:**
  - WR0 drives `memWR=1`, `addWR=addR=addr`, `dataWR` = high half (dbl) or `wdata[width-1:0]` (single).
  - After WR0: go to WR1 if dbl, otherwise return to IDLE with `done`.
  - WR1 drives `addr+1` with the low half, then returns to IDLE with `done`.
- **Loads:**
  - RD0 drives `memR=1` and `addR=addWR=addr`. Both addresses are driven identically during reads.
  - RD0W holds `memR` and the address, and captures `dataR` at the end of the cycle.
    - Single: `rdata={0,dataR}`.
    - Double: capture into `rdata[2*width-1:width]`, then go to RD1.
  - RD1 and RD1W repeat this at `addr+1` into `rdata[width-1:0]`.
  - The high half of a double load is not visible as final until `done`.
- **Memory-side outputs:**
  - Decoded only from the state register and the latched request, never combinationally from `req`.
  - `memR` and `memWR` are never both high.
  - Outside WR*/RD* states all memory-side outputs are 0.
- **Reset:**
  - `rst` forces IDLE and clears `busy`, `done`, `rdata`, `memR`, `memWR`, `addR`, `addWR` and `dataWR` to 0.
  - Reset mid-operation aborts the transaction. Any write already performed stays in memory; no `done` is issued.

## Timing
- Request sampled at the edge ending cycle T. `busy=1` from T+1.
- **Single store:**
  - `memWR` in T+1.
  - `done=1`, `busy=0` in T+2.
- **Double store:**
  - `memWR` in T+1 and T+2.
  - `done` in T+3.
- **Single load:**
  - `memR` in T+1 and T+2.
  - `rdata` valid and `done` in T+3.
- **Double load:**
  - `memR` in T+1 to T+4.
  - `done` in T+5, with `rdata` valid in that same cycle.
- **Back-to-back:** the `done` cycle is an IDLE cycle.
  - A `req` present then is accepted, giving zero dead cycles between transactions.
  - `busy` is low in the `done` cycle and high again the next cycle.
- **Reset priority:** `rst` and `req` in the same cycle resolve to reset; the request is dropped.

## Structure
- State encodings (3-bit localparams) and default `addBusWidth`/`width` values go in the shared memory-definitions include, shared with the memory and the hazard unit.
- Single module; no sub-module.
- The `addr+1` incrementer and the half-select mux are inline.

## Test plan
- **Single store then load:** store `addr=0x5`, `wdata=0x0000_BEEF`; then load `0x5`.
  - Store: `memWR` one cycle with `dataWR=0xBEEF`, `done` at T+2.
  - Load: `rdata=0x0000_BEEF`, `done` at T+3.
- **Double store/load:** store `addr=0x10`, `wdata=0x1234_ABCD`.
  - Memory receives `[0x10]=0x1234` and `[0x11]=0xABCD`.
  - A double load of `0x10` returns `0x1234_ABCD` with `done` at T+5.
- **Wrap-around:** double store at `addr=0xFFFF_FFFF`.
  - Second write goes to `addWR=0x0000_0000`.
- **Back-to-back and ignored request:**
  - A store `req` held in the `done` cycle of the previous load is accepted with no idle gap.
  - A `req` pulsed while `busy=1` produces no extra transaction.
- **Reset mid-operation:** assert `rst` in RD1 of a double load.
  - Next cycle: IDLE, `busy=0`, `memR=0`, `rdata=0`; no `done` pulse.
- **Mutual exclusion:** assert every cycle that `memR & memWR` never occurs and that `done` is never high two consecutive cycles.
